// File: rtl/cap_code_sequencer_pkg.sv
// Shared types and defaults for the capacitor code sequencer: state encoding,
// code width and default timing constants.
package cap_code_sequencer_pkg;

  localparam int unsigned QCM_CODE_WIDTH   = 7;
  localparam int unsigned DefSyncStages    = 2;
  localparam int unsigned DefStableCycles  = 16;
  localparam int unsigned DefDeadCycles    = 64;
  localparam int unsigned DefMinDwell      = 256;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StQualify = 3'd1,
    StBreak   = 3'd2,
    StDead    = 3'd3,
    StMake    = 3'd4,
    StHold    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/cap_code_sync.sv
// Multi-flop synchronizer for the asynchronous backplane code and its ready bit.
module cap_code_sync #(
  parameter int unsigned WIDTH       = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_code,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_code,
  output logic             o_en
);

  logic [WIDTH:0] r_sync [SYNC_STAGES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= {i_enable, i_code};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign {o_en, o_code} = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cap_code_sequencer.sv
// Qualifies a synchronized tuning code and applies it to the capacitor switches
// with break-before-make sequencing and a minimum dwell after every change.
module cap_code_sequencer
  import cap_code_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH         = QCM_CODE_WIDTH,
  parameter int unsigned SYNC_STAGES   = DefSyncStages,
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned DEAD_CYCLES   = DefDeadCycles,
  parameter int unsigned MIN_DWELL     = DefMinDwell
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] code_in,
  input  logic             enable_in,
  output logic [WIDTH-1:0] caps_out,
  output logic [WIDTH-1:0] applied_code,
  output logic             busy,
  output logic             done
);

  localparam int unsigned StabW  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned DeadW  = $clog2(DEAD_CYCLES + 1);
  localparam int unsigned DwellW = $clog2(MIN_DWELL + 1);

  localparam logic [StabW-1:0]  StabLast  = StabW'(STABLE_CYCLES - 1);
  localparam logic [DeadW-1:0]  DeadLoad  = DeadW'(DEAD_CYCLES);
  localparam logic [DwellW-1:0] DwellLoad = DwellW'(MIN_DWELL);

  logic [WIDTH-1:0]  w_code_s;
  logic              w_en_s;

  seq_state_e        r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_cand, w_cand_nxt;
  logic [WIDTH-1:0]  r_target, w_target_nxt;
  logic [WIDTH-1:0]  r_caps, w_caps_nxt;
  logic [WIDTH-1:0]  r_applied, w_applied_nxt;
  logic              r_done, w_done_nxt;
  logic [StabW-1:0]  r_stab_cnt, w_stab_nxt;
  logic [DeadW-1:0]  r_dead_cnt, w_dead_nxt;
  logic [DwellW-1:0] r_dwell_cnt, w_dwell_nxt;
  logic              w_go_break, w_go_make;
  logic [WIDTH-1:0]  w_break_code;

  cap_code_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_code   (code_in),
    .i_enable (enable_in),
    .o_code   (w_code_s),
    .o_en     (w_en_s)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cand_nxt    = r_cand;
    w_target_nxt  = r_target;
    w_caps_nxt    = r_caps;
    w_applied_nxt = r_applied;
    w_done_nxt    = 1'b0;
    w_stab_nxt    = r_stab_cnt;
    w_dead_nxt    = r_dead_cnt;
    w_dwell_nxt   = r_dwell_cnt;
    w_go_break    = 1'b0;
    w_go_make     = 1'b0;
    w_break_code  = r_cand;

    case (r_state)
      StIdle: begin
        if (w_en_s && (w_code_s != r_applied)) begin
          w_cand_nxt = w_code_s;
          w_stab_nxt = StabW'(1);
          if (STABLE_CYCLES == 1) begin
            w_go_break   = 1'b1;
            w_break_code = w_code_s;
          end else begin
            w_state_nxt = StQualify;
          end
        end
      end
      StQualify: begin
        if (!w_en_s) begin
          w_state_nxt = StIdle;
        end else if (w_code_s != r_cand) begin
          w_cand_nxt = w_code_s;
          w_stab_nxt = StabW'(1);
        end else begin
          w_stab_nxt = r_stab_cnt + 1'b1;
          if (r_stab_cnt == StabLast) begin
            w_go_break = 1'b1;
          end
        end
      end
      StBreak: begin
        // caps_out already equals applied_code before the break, so this is the removal mask.
        if ((r_applied & ~r_target) == '0) begin
          w_go_make = 1'b1;
        end else begin
          w_dead_nxt  = DeadLoad;
          w_state_nxt = StDead;
        end
      end
      StDead: begin
        if (r_dead_cnt == DeadW'(1)) begin
          w_go_make = 1'b1;
        end else begin
          w_dead_nxt = r_dead_cnt - 1'b1;
        end
      end
      StMake: begin
        w_dwell_nxt = DwellLoad;
        w_state_nxt = StHold;
      end
      StHold: begin
        if (r_dwell_cnt == DwellW'(1)) begin
          w_state_nxt = StIdle;
        end else begin
          w_dwell_nxt = r_dwell_cnt - 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // Outputs are registered, so the break/make actions land on the edge entering the state.
    if (w_go_break) begin
      w_state_nxt  = StBreak;
      w_target_nxt = w_break_code;
      w_caps_nxt   = r_caps & w_break_code;
    end
    if (w_go_make) begin
      w_state_nxt   = StMake;
      w_caps_nxt    = r_target;
      w_applied_nxt = r_target;
      w_done_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cand      <= '0;
      r_target    <= '0;
      r_caps      <= '0;
      r_applied   <= '0;
      r_done      <= 1'b0;
      r_stab_cnt  <= '0;
      r_dead_cnt  <= '0;
      r_dwell_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_target    <= w_target_nxt;
      r_caps      <= w_caps_nxt;
      r_applied   <= w_applied_nxt;
      r_done      <= w_done_nxt;
      r_stab_cnt  <= w_stab_nxt;
      r_dead_cnt  <= w_dead_nxt;
      r_dwell_cnt <= w_dwell_nxt;
    end
  end

  assign caps_out     = r_caps;
  assign applied_code = r_applied;
  assign busy         = (r_state != StIdle);
  assign done         = r_done;

endmodule

// File: tb/tb_cap_code_sequencer.sv
// Randomized bench for cap_code_sequencer: a segment-level reference model predicts
// every applied code and the caps/busy waveform; a monitor scores the DUT against it.
module tb_cap_code_sequencer;

  localparam int SYN   = 2;
  localparam int STB   = 4;
  localparam int DEADC = 8;
  localparam int DWELL = 16;
  localparam int NMAX  = 4000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] code_in = '0;
  logic       enable_in = 1'b0;
  logic [6:0] caps_out, applied_code;
  logic       busy, done;

  cap_code_sequencer #(
    .WIDTH         (7),
    .SYNC_STAGES   (SYN),
    .STABLE_CYCLES (STB),
    .DEAD_CYCLES   (DEADC),
    .MIN_DWELL     (DWELL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .code_in      (code_in),
    .enable_in    (enable_in),
    .caps_out     (caps_out),
    .applied_code (applied_code),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {int b; int m; logic [6:0] oldc; logic [6:0] newc;} ev_t;
  typedef struct {int m; logic [6:0] code;} sb_t;

  // in_*[n] is the input presented just before edge n.
  bit         in_en   [NMAX];
  logic [6:0] in_code [NMAX];
  bit         exp_busy [NMAX];
  logic [6:0] exp_caps [NMAX];
  logic [6:0] exp_app  [NMAX];
  ev_t        evs[$];
  sb_t        sb_q[$];
  int         n_len = 0;
  int         cyc = -1;
  int         rst_edge = NMAX;
  int         checks = 0;
  int         passed = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s edge=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
  endtask

  task automatic add_seg(input bit en, input logic [6:0] code, input int len);
    for (int i = 0; i < len; i++) begin
      if (n_len < NMAX) begin
        in_en[n_len]   = en;
        in_code[n_len] = code;
        n_len++;
      end
    end
  endtask

  // Synchronized view seen by the sequencer at edge t.
  function automatic bit s_en(input int t);
    int i = t - SYN;
    return (i < 0 || i >= n_len) ? 1'b0 : in_en[i];
  endfunction

  function automatic logic [6:0] s_code(input int t);
    int i = t - SYN;
    return (i < 0 || i >= n_len) ? 7'h00 : in_code[i];
  endfunction

  // A run starts on an enabled sample differing from the applied code while idle;
  // it commits once one code is seen STB samples in a row, and aborts on enable low.
  task automatic run_model();
    int         t, s, len;
    bit         fin;
    logic [6:0] app, cand, cur;
    ev_t        e;
    t = 0;
    app = '0;
    while (t < n_len + SYN) begin
      if (s_en(t) && s_code(t) != app) begin
        s = t;
        cand = s_code(t);
        len = 1;
        fin = 1'b0;
        while (!fin) begin
          if (len == STB) begin
            e.b = t;
            e.oldc = app;
            e.newc = cand;
            e.m = ((app & ~cand) != 0) ? t + DEADC + 1 : t + 1;
            evs.push_back(e);
            for (int k = s; k <= e.m + DWELL && k < NMAX; k++) exp_busy[k] = 1'b1;
            app = cand;
            t = e.m + DWELL + 2;
            fin = 1'b1;
          end else begin
            t++;
            if (!s_en(t)) begin
              for (int k = s; k < t && k < NMAX; k++) exp_busy[k] = 1'b1;
              t++;
              fin = 1'b1;
            end else if (s_code(t) != cand) begin
              cand = s_code(t);
              len = 1;
            end else begin
              len++;
            end
          end
        end
      end else begin
        t++;
      end
    end
    cur = '0;
    for (int n = 0, k = 0; n < NMAX; n++) begin
      if (k < evs.size() && n >= evs[k].m) begin
        cur = evs[k].newc;
        k++;
      end
      exp_app[n]  = cur;
      exp_caps[n] = (k < evs.size() && n >= evs[k].b) ? (cur & evs[k].newc) : cur;
    end
  endtask

  task automatic drive(input int n);
    if (n < n_len) begin
      enable_in = in_en[n];
      code_in   = in_code[n];
    end else begin
      enable_in = 1'b0;
      code_in   = '0;
    end
  endtask

  initial begin
    logic [6:0] rc;
    rc = 7'h00;
    add_seg(1'b1, 7'h00, 100);
    add_seg(1'b1, 7'h15, 40);
    add_seg(1'b1, 7'h0A, 50);
    add_seg(1'b0, 7'h00, 10);
    add_seg(1'b1, 7'h40, 3);
    add_seg(1'b1, 7'h41, 40);
    add_seg(1'b0, 7'h41, 10);
    add_seg(1'b1, 7'h22, 2);
    add_seg(1'b0, 7'h22, 20);
    add_seg(1'b1, 7'h33, 20);
    add_seg(1'b1, 7'h7F, 60);
    add_seg(1'b1, 7'h01, 9);
    add_seg(1'b0, 7'h01, 40);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) != 0) rc = 7'($urandom_range(0, 127));
      add_seg($urandom_range(0, 3) != 0, rc, $urandom_range(1, 40));
    end
    add_seg(1'b0, 7'h00, 40);
    add_seg(1'b1, 7'h7E, 60);
    add_seg(1'b0, 7'h00, 20);
    add_seg(1'b1, 7'h01, 60);
    add_seg(1'b0, 7'h00, 20);
    add_seg(1'b1, 7'h00, 60);
    run_model();
    if (evs.size() == 0 || evs[evs.size()-1].newc != 7'h00) begin
      $display("FAIL model_setup final event is not the all-removed code");
      $fatal(1, "bench setup");
    end
    // Reset lands while the final sequence is in its dead time.
    rst_edge = evs[evs.size()-1].b + 3;
    foreach (evs[i]) if (evs[i].m < rst_edge) sb_q.push_back('{m: evs[i].m, code: evs[i].newc});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_caps", caps_out, 0);
    check("reset_applied", applied_code, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;
    drive(0);
    for (int n = 0; n < rst_edge; n++) begin
      @(posedge clk);
      cyc = n;
      @(negedge clk);
      if (n == rst_edge - 1) rst = 1'b1;
      else drive(n + 1);
    end
    @(posedge clk);
    cyc = rst_edge;
    @(negedge clk);
    check("midseq_reset_caps", caps_out, 0);
    check("midseq_reset_applied", applied_code, 0);
    check("midseq_reset_busy", busy, 0);
    check("midseq_reset_done", done, 0);
    check("pending_dones", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Monitor: waveform checks against the model, plus break-before-make invariants.
  logic [6:0] prev_caps = '0;
  always @(negedge clk) begin
    sb_t        e;
    logic [6:0] gained, lost;
    if (cyc >= 0 && cyc < rst_edge) begin
      check("caps", caps_out, exp_caps[cyc]);
      check("applied", applied_code, exp_app[cyc]);
      check("busy", busy, exp_busy[cyc]);
      gained = caps_out & ~prev_caps;
      lost   = prev_caps & ~caps_out;
      check("no_gain_with_loss", (gained != 0 && lost != 0), 0);
      if (gained != 0) check("gain_only_with_done", done, 1);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", cyc, -1);
        end else begin
          e = sb_q.pop_front();
          check("done_edge", cyc, e.m);
          check("done_caps", caps_out, e.code);
          check("done_applied", applied_code, e.code);
        end
      end
      prev_caps = caps_out;
    end
  end

endmodule
